// File: rtl/lcd_pkg.sv
// Shared definitions for the DMG LCD timing generator.
// Holds the default panel timing, counter widths, the 2-bit pixel type
// and the line-phase state encoding.
package lcd_pkg;

    localparam int H_ACTIVE   = 160;  // pixels per line
    localparam int V_ACTIVE   = 144;  // visible lines
    localparam int H_TOTAL    = 456;  // dots per line
    localparam int V_TOTAL    = 154;  // lines per frame
    localparam int H_START    = 80;   // dot at which pixel acceptance opens
    localparam int H_DEADLINE = 452;  // dot at which an unfinished line is force-latched

    localparam int DOT_W = 9;
    localparam int LY_W  = 8;
    localparam int PX_W  = 8;

    typedef logic [1:0] pixel_t;

    typedef enum logic [2:0] {
        S_OFF,
        S_PRE,
        S_ACTIVE,
        S_LATCH,
        S_POST,
        S_VBLANK
    } lcd_state_t;

endpackage

// File: rtl/lcd_dot_counter.sv
// Dot / line timebase for the LCD timing generator.
//   clk, reset   : dot clock, synchronous active-high reset
//   lcd_en       : display enable; counters are held at 0 while low
//   running      : display was already enabled last cycle (registered cpg)
//   dot, ly      : current dot 0..H_TOTAL-1 and line 0..V_TOTAL-1
//   line_start   : the coming clock edge begins dot 0 of a new line
//   frame_start  : the coming clock edge begins dot 0 of line 0
// The strobes are look-ahead so the controller can register its
// line-start outputs to be valid exactly at dot 0.
module lcd_dot_counter
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             lcd_en,
    input  logic             running,
    output logic [DOT_W-1:0] dot,
    output logic [LY_W-1:0]  ly,
    output logic             line_start,
    output logic             frame_start
);

    logic active;
    logic dot_wrap;
    logic ly_wrap;

    assign active   = ~reset & lcd_en;
    assign dot_wrap = (dot == DOT_W'(H_TOTAL - 1));
    assign ly_wrap  = (ly == LY_W'(V_TOTAL - 1));

    // First enabled cycle counts as a fresh frame start at dot 0 / line 0.
    assign line_start  = active & (~running | dot_wrap);
    assign frame_start = active & (~running | (dot_wrap & ly_wrap));

    always_ff @(posedge clk) begin
        if (!active || !running) begin
            dot <= '0;
            ly  <= '0;
        end else if (dot_wrap) begin
            dot <= '0;
            ly  <= ly_wrap ? '0 : ly + LY_W'(1);
        end else begin
            dot <= dot + DOT_W'(1);
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD interface driver: takes 2-bit pixels from the PPU pixel FIFO over
// valid/ready and produces the panel strobes and pixel data.
//   clk, reset          : dot clock, synchronous active-high reset
//   lcd_en              : LCDC display enable
//   pix_valid, pix_data : incoming pixel stream
//   pix_ready           : pixel accepted this cycle when pix_valid is high
//   cpg                 : display enabled
//   cp, st              : pixel clock pulse, horizontal sync with first pixel
//   cpl                 : line latch pulse
//   fr                  : drive polarity, toggles every line
//   s                   : vertical sync, high for all of line 0
//   ld                  : pixel data {ld1, ld0}
//   ly                  : current line
//   underrun            : sticky, a line was latched short of pixels
//
// state    | meaning
// S_OFF    | display disabled, all outputs held low
// S_PRE    | visible line, before pixel acceptance opens
// S_ACTIVE | accepting pixels, at most one every two clocks
// S_LATCH  | waiting for the last cp to fall, then one-cycle cpl
// S_POST   | line latched, idle until dot wrap
// S_VBLANK | vertical blanking line, no pixel activity
module lcd_timing_gen
    import lcd_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            lcd_en,
    input  logic            pix_valid,
    input  pixel_t          pix_data,
    output logic            pix_ready,
    output logic            cpg,
    output logic            cp,
    output logic            cpl,
    output logic            fr,
    output logic            st,
    output logic            s,
    output pixel_t          ld,
    output logic [LY_W-1:0] ly,
    output logic            underrun
);

    lcd_state_t       state;
    logic [PX_W-1:0]  px_cnt;
    logic [DOT_W-1:0] dot;
    logic             line_start;
    logic             frame_start;
    logic             hs;

    lcd_dot_counter u_dot_counter (
        .clk         (clk),
        .reset       (reset),
        .lcd_en      (lcd_en),
        .running     (cpg),
        .dot         (dot),
        .ly          (ly),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    assign pix_ready = (state == S_ACTIVE) && !cp && (px_cnt < PX_W'(H_ACTIVE));
    assign hs        = pix_valid & pix_ready;

    always_ff @(posedge clk) begin
        if (reset || !lcd_en) begin
            state    <= S_OFF;
            cpg      <= 1'b0;
            cp       <= 1'b0;
            cpl      <= 1'b0;
            fr       <= 1'b0;
            st       <= 1'b0;
            s        <= 1'b0;
            ld       <= '0;
            px_cnt   <= '0;
            underrun <= 1'b0;
        end else begin
            cpg <= 1'b1;
            // pix_ready is low while cp is high, so cp is always a single-cycle pulse
            cp  <= hs;
            st  <= hs && (px_cnt == '0);
            if (hs) begin
                ld     <= pix_data;
                px_cnt <= px_cnt + PX_W'(1);
            end

            if (line_start) begin
                fr    <= ~fr;
                s     <= frame_start;
                cpl   <= 1'b0;
                // frame_start means the next line is 0; otherwise it is ly+1
                state <= (frame_start || ly < LY_W'(V_ACTIVE - 1)) ? S_PRE : S_VBLANK;
            end else begin
                case (state)
                    S_PRE: begin
                        if (dot == DOT_W'(H_START - 1)) begin
                            state  <= S_ACTIVE;
                            px_cnt <= '0;
                        end
                    end
                    S_ACTIVE: begin
                        if (!cp && px_cnt == PX_W'(H_ACTIVE)) begin
                            state <= S_LATCH;
                            cpl   <= 1'b1;
                        end else if (dot == DOT_W'(H_DEADLINE - 1) && px_cnt < PX_W'(H_ACTIVE)) begin
                            // Leave ACTIVE so cpl can land on the deadline dot. A pixel
                            // accepted now or still on cp finishes first and LATCH
                            // raises cpl the cycle after its cp falls.
                            state <= S_LATCH;
                            cpl   <= !cp && !hs;
                            if (!(hs && px_cnt == PX_W'(H_ACTIVE - 1))) begin
                                underrun <= 1'b1;
                            end
                        end
                    end
                    S_LATCH: begin
                        if (cpl) begin
                            state <= S_POST;
                            cpl   <= 1'b0;
                        end else if (!cp) begin
                            cpl <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
module tb_lcd_timing_gen;

    localparam int HT       = 456;
    localparam int VT       = 154;
    localparam int VA       = 144;
    localparam int HA       = 160;
    localparam int HS0      = 80;
    localparam int HDL      = 452;
    localparam int FRAME_CYC = HT * VT;

    typedef struct packed {
        logic       ready;
        logic       cpg;
        logic       cp;
        logic       cpl;
        logic       fr;
        logic       st;
        logic       s;
        logic [1:0] ld;
        logic [7:0] ly;
        logic       underrun;
    } out_t;

    typedef struct {
        logic rst;
        logic en;
        out_t exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       lcd_en;
    logic       pix_valid;
    logic [1:0] pix_data;
    logic       pix_ready;
    logic       cpg, cp, cpl, fr, st, s;
    logic [1:0] ld;
    logic [7:0] ly;
    logic       underrun;

    int checks   = 0;
    int failures = 0;

    // reference model state: cycles since enable, pixels in current line,
    // dot of last accepted pixel, cp/st pipeline, held data, sticky flag
    int         c;
    int         cnt;
    int         last_d;
    bit         prev_hs;
    bit         prev_first;
    logic [1:0] m_ld;
    bit         m_ur;

    lcd_timing_gen dut (
        .clk       (clk),
        .reset     (reset),
        .lcd_en    (lcd_en),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .cpg       (cpg),
        .cp        (cp),
        .cpl       (cpl),
        .fr        (fr),
        .st        (st),
        .s         (s),
        .ld        (ld),
        .ly        (ly),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog c=%0d got=timeout required=finish", c);
        $fatal(1, "watchdog expired");
    end

    function automatic out_t get_dut();
        out_t o;
        o.ready    = pix_ready;
        o.cpg      = cpg;
        o.cp       = cp;
        o.cpl      = cpl;
        o.fr       = fr;
        o.st       = st;
        o.s        = s;
        o.ld       = ld;
        o.ly       = ly;
        o.underrun = underrun;
        return o;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t got;
        got = get_dut();
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s c=%0d dot=%0d got=%h required=%h", name, c, c % HT, got, exp);
        end
    endtask

    task automatic model_reset();
        c          = 0;
        cnt        = 0;
        last_d     = -10;
        prev_hs    = 0;
        prev_first = 0;
        m_ld       = 2'b00;
        m_ur       = 0;
    endtask

    // One dot: drive inputs, check the current cycle against the timing
    // rules, advance the model, move to just after the next rising edge.
    task automatic sim_cycle(input bit v, input logic [1:0] d);
        int   dot;
        int   line;
        int   lyv;
        int   dl;
        bit   vis;
        bit   hs;
        out_t exp;
        dot  = c % HT;
        line = c / HT;
        lyv  = line % VT;
        vis  = (lyv < VA);
        if (vis && dot == HDL && cnt < HA) m_ur = 1;
        dl = (last_d + 3 > HDL) ? last_d + 3 : HDL;
        exp.cpl = 1'b0;
        if (vis) begin
            if (cnt == HA) exp.cpl = (dot == last_d + 3);
            else           exp.cpl = (dot >= HDL) && (dot == dl);
        end
        exp.ready    = vis && dot >= HS0 && dot < HDL && cnt < HA && !prev_hs;
        exp.cpg      = 1'b1;
        exp.cp       = prev_hs;
        exp.fr       = (line % 2 == 0);
        exp.st       = prev_hs && prev_first;
        exp.s        = (lyv == 0);
        exp.ld       = m_ld;
        exp.ly       = 8'(lyv);
        exp.underrun = m_ur;
        pix_valid = v;
        pix_data  = d;
        @(negedge clk);
        check("cycle", exp);
        hs         = v && exp.ready;
        prev_first = hs && (cnt == 0);
        if (hs) begin
            cnt++;
            last_d = dot;
            m_ld   = d;
        end
        prev_hs = hs;
        c++;
        if (c % HT == 0) begin
            cnt    = 0;
            last_d = -10;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_off(input string name);
        @(negedge clk);
        check(name, '0);
        @(posedge clk);
        #1;
    endtask

    vec_t       vecs[4];
    out_t       en_exp;
    int         gap_left;
    int         dotv;
    int         linev;
    bit         v;

    initial begin
        en_exp     = '0;
        en_exp.cpg = 1'b1;
        en_exp.s   = 1'b1;
        en_exp.fr  = 1'b1;
        vecs[0] = '{rst: 1'b1, en: 1'b0, exp: '0};
        vecs[1] = '{rst: 1'b1, en: 1'b1, exp: '0};
        vecs[2] = '{rst: 1'b0, en: 1'b0, exp: '0};
        vecs[3] = '{rst: 1'b0, en: 1'b1, exp: en_exp};

        reset     = 1'b1;
        lcd_en    = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 2'b00;
        model_reset();
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            reset     = vecs[i].rst;
            lcd_en    = vecs[i].en;
            pix_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full frame plus the start of the next one, varying the feed per line.
        model_reset();
        gap_left = 0;
        while (c < FRAME_CYC + 101) begin
            dotv  = c % HT;
            linev = c / HT;
            if (dotv == 0) gap_left = 24;
            if (linev < 3 || linev >= VT) begin
                v = 1;
            end else if (linev < 10) begin
                v = 1;
                if (gap_left > 0 && $urandom_range(0, 3) == 0) begin
                    v = 0;
                    gap_left--;
                end
            end else if (linev == 10) begin
                v = (cnt < 100);
            end else if (linev == 11) begin
                v = (dotv >= 449);
            end else if (linev == 12) begin
                v = (dotv == 450);
            end else begin
                v = ($urandom_range(0, 3) != 0);
            end
            sim_cycle(v, 2'($urandom_range(0, 3)));
        end

        // Disable while a pixel is on cp (dot 101 of line 0, second frame).
        lcd_en = 1'b0;
        sim_cycle(1'b1, 2'($urandom_range(0, 3)));
        for (int i = 0; i < 3; i++) check_off($sformatf("off%0d", i));

        lcd_en = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        repeat (600) sim_cycle(1'b1, 2'($urandom_range(0, 3)));

        // Reset mid-line with the display still enabled.
        reset = 1'b1;
        sim_cycle(1'b1, 2'($urandom_range(0, 3)));
        check_off("reset_mid");
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        repeat (200) sim_cycle(1'b1, 2'($urandom_range(0, 3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
